// File: rtl/ensemble_pkg.sv
// rtl/ensemble_pkg.sv - shared state encoding, result-word layout and width helpers for the vote engine
package ensemble_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VOTE    = 2'd1,
        OUTPUT  = 2'd2
    } vote_state_t;

    localparam int LABEL_LSB     = 0;
    localparam int COUNT_FIELD_W = 8;

    function automatic int count_lsb(input int label_width);
        return LABEL_LSB + label_width;
    endfunction

    function automatic int unanimous_bit(input int data_width);
        return data_width - 2;
    endfunction

    function automatic int timeout_bit(input int data_width);
        return data_width - 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ensemble_bcast_fork.sv
// rtl/ensemble_bcast_fork.sv - lossless N-way AXIS broadcast; sent[] remembers which channels already took the beat
module ensemble_bcast_fork #(
    parameter int NUM_CLASSIFIERS = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]                 s_axis_tkeep,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,
    output logic [NUM_CLASSIFIERS*DATA_WIDTH-1:0] cls_in_tdata,
    output logic [NUM_CLASSIFIERS*KEEP_WIDTH-1:0] cls_in_tkeep,
    output logic [NUM_CLASSIFIERS-1:0]            cls_in_tvalid,
    input  logic [NUM_CLASSIFIERS-1:0]            cls_in_tready,
    output logic [NUM_CLASSIFIERS-1:0]            cls_in_tlast
);

    logic [NUM_CLASSIFIERS-1:0] sent_q;
    logic                       in_hs;

    assign cls_in_tdata  = {NUM_CLASSIFIERS{s_axis_tdata}};
    assign cls_in_tkeep  = {NUM_CLASSIFIERS{s_axis_tkeep}};
    assign cls_in_tlast  = {NUM_CLASSIFIERS{s_axis_tlast}};
    assign cls_in_tvalid = {NUM_CLASSIFIERS{s_axis_tvalid}} & ~sent_q;
    assign s_axis_tready = &(sent_q | cls_in_tready);
    assign in_hs         = s_axis_tvalid & s_axis_tready;

    // A channel that already took the current beat is masked until every channel has it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_q <= '0;
        end else if (in_hs) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_q | (cls_in_tvalid & cls_in_tready);
        end
    end

endmodule

// File: rtl/ensemble_vote_engine.sv
// rtl/ensemble_vote_engine.sv - N-way classifier ensemble with sequential plurality vote; optional ENSEMBLE_TIMEOUT_EN
module ensemble_vote_engine
    import ensemble_pkg::*;
#(
    parameter int NUM_CLASSIFIERS = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = 4,
    parameter int LABEL_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]                 s_axis_tkeep,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,
    output logic [NUM_CLASSIFIERS*DATA_WIDTH-1:0] cls_in_tdata,
    output logic [NUM_CLASSIFIERS*KEEP_WIDTH-1:0] cls_in_tkeep,
    output logic [NUM_CLASSIFIERS-1:0]            cls_in_tvalid,
    input  logic [NUM_CLASSIFIERS-1:0]            cls_in_tready,
    output logic [NUM_CLASSIFIERS-1:0]            cls_in_tlast,
    input  logic [NUM_CLASSIFIERS*DATA_WIDTH-1:0] cls_out_tdata,
    input  logic [NUM_CLASSIFIERS-1:0]            cls_out_tvalid,
    output logic [NUM_CLASSIFIERS-1:0]            cls_out_tready,
    input  logic [NUM_CLASSIFIERS-1:0]            cls_out_tlast,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                 m_axis_tkeep,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast
);

    localparam int N             = NUM_CLASSIFIERS;
    localparam int CW            = cnt_width(N);
    localparam int IW            = (N > 1) ? $clog2(N) : 1;
    localparam int COUNT_LSB     = count_lsb(LABEL_WIDTH);
    localparam int UNANIMOUS_BIT = unanimous_bit(DATA_WIDTH);
    localparam int TIMEOUT_BIT   = timeout_bit(DATA_WIDTH);

    vote_state_t            state_q, state_d;
    logic [N-1:0]           got_q, got_set, acc, stale;
    logic [LABEL_WIDTH-1:0] label_q [N];
    logic [IW-1:0]          idx_q;
    logic [LABEL_WIDTH-1:0] cur_lbl, best_lbl_q;
    logic [CW-1:0]          vote_cnt, best_cnt_q;
    logic                   tmo_flag_q, tmo_hit;
    logic                   m_tvalid_q;
    logic [DATA_WIDTH-1:0]  m_tdata_q, result;
    logic                   unused_ok;

    ensemble_bcast_fork #(
        .NUM_CLASSIFIERS(N),
        .DATA_WIDTH     (DATA_WIDTH),
        .KEEP_WIDTH     (KEEP_WIDTH)
    ) u_fork (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .cls_in_tdata (cls_in_tdata),
        .cls_in_tkeep (cls_in_tkeep),
        .cls_in_tvalid(cls_in_tvalid),
        .cls_in_tready(cls_in_tready),
        .cls_in_tlast (cls_in_tlast)
    );

    assign cls_out_tready = (state_q == COLLECT) ? ~got_q : '0;
    assign acc            = cls_out_tvalid & cls_out_tready;
    assign got_set        = got_q | (acc & cls_out_tlast & ~stale);
    assign unused_ok      = ^{cls_out_tdata, TIMEOUT_CYCLES > 0};

`ifdef ENSEMBLE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt_q;
    logic [N-1:0]  stale_q;

    assign stale   = stale_q;
    assign tmo_hit = (state_q == COLLECT) && (|got_q) && !(&got_set)
                     && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Channels missing at timeout owe one late tlast beat, which is swallowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            stale_q   <= '0;
        end else begin
            if (state_q != COLLECT || got_q == '0) tmo_cnt_q <= '0;
            else if (!tmo_hit)                     tmo_cnt_q <= tmo_cnt_q + TW'(1);
            for (int i = 0; i < N; i++) begin
                if (acc[i] && cls_out_tlast[i] && stale_q[i]) stale_q[i] <= 1'b0;
            end
            if (tmo_hit) stale_q <= ~got_set;
        end
    end
`else
    assign stale   = '0;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        cur_lbl  = label_q[idx_q];
        vote_cnt = '0;
        for (int j = 0; j < N; j++) begin
            if (got_q[j] && label_q[j] == cur_lbl) vote_cnt = vote_cnt + CW'(1);
        end
    end

    always_comb begin
        result                                = '0;
        result[LABEL_LSB +: LABEL_WIDTH]      = best_lbl_q;
        result[COUNT_LSB +: COUNT_FIELD_W]    = COUNT_FIELD_W'(best_cnt_q);
        result[UNANIMOUS_BIT]                 = (best_cnt_q == CW'(N));
        result[TIMEOUT_BIT]                   = tmo_flag_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if ((&got_set) || tmo_hit)           state_d = VOTE;
            VOTE:    if (idx_q == IW'(N - 1))             state_d = OUTPUT;
            OUTPUT:  if (m_tvalid_q && m_axis_tready)     state_d = COLLECT;
            default:                                      state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            got_q      <= '0;
            idx_q      <= '0;
            best_lbl_q <= '0;
            best_cnt_q <= '0;
            tmo_flag_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            for (int i = 0; i < N; i++) label_q[i] <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && !stale[i]) label_q[i] <= cls_out_tdata[i*DATA_WIDTH +: LABEL_WIDTH];
            end
            case (state_q)
                COLLECT: begin
                    got_q <= got_set;
                    idx_q <= '0;
                    if (tmo_hit) tmo_flag_q <= 1'b1;
                end
                VOTE: begin
                    // Strict compare keeps the lowest-index label on ties.
                    if (got_q[idx_q] && vote_cnt > best_cnt_q) begin
                        best_lbl_q <= cur_lbl;
                        best_cnt_q <= vote_cnt;
                    end
                    idx_q <= idx_q + IW'(1);
                end
                OUTPUT: begin
                    if (!m_tvalid_q) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= result;
                    end else if (m_axis_tready) begin
                        m_tvalid_q <= 1'b0;
                        m_tdata_q  <= '0;
                        got_q      <= '0;
                        best_lbl_q <= '0;
                        best_cnt_q <= '0;
                        tmo_flag_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = m_tvalid_q;

endmodule

// File: tb/tb_ensemble_vote_engine.sv
// tb/tb_ensemble_vote_engine.sv - directed self-checking bench for ensemble_vote_engine
module tb_ensemble_vote_engine;

    localparam int N   = 3;
    localparam int DW  = 32;
    localparam int KW  = 4;
    localparam int LW  = 8;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [N*DW-1:0] cls_in_tdata;
    logic [N*KW-1:0] cls_in_tkeep;
    logic [N-1:0]    cls_in_tvalid;
    logic [N-1:0]    cls_in_tready;
    logic [N-1:0]    cls_in_tlast;
    logic [N*DW-1:0] cls_out_tdata;
    logic [N-1:0]    cls_out_tvalid;
    logic [N-1:0]    cls_out_tready;
    logic [N-1:0]    cls_out_tlast;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;

    int checks   = 0;
    int failures = 0;

    int            rx_cnt  [N];
    logic [DW-1:0] rx_data [N][8];

    ensemble_vote_engine #(
        .NUM_CLASSIFIERS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .LABEL_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .cls_in_tdata(cls_in_tdata), .cls_in_tkeep(cls_in_tkeep),
        .cls_in_tvalid(cls_in_tvalid), .cls_in_tready(cls_in_tready),
        .cls_in_tlast(cls_in_tlast),
        .cls_out_tdata(cls_out_tdata), .cls_out_tvalid(cls_out_tvalid),
        .cls_out_tready(cls_out_tready), .cls_out_tlast(cls_out_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (cls_in_tvalid[i] && cls_in_tready[i]) begin
                rx_data[i][rx_cnt[i] % 8] <= cls_in_tdata[i*DW +: DW];
                rx_cnt[i] <= rx_cnt[i] + 1;
            end
        end
    end

    task automatic send_results(input logic [N-1:0] mask, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        cls_out_tdata  = {d2, d1, d0};
        cls_out_tvalid = mask;
        cls_out_tlast  = mask;
        @(posedge clk); #1;
        cls_out_tvalid = '0;
        cls_out_tlast  = '0;
    endtask

    task automatic wait_mvalid(output int cyc);
        cyc = 0;
        while (m_axis_tvalid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h0) begin failures++; $display("FAIL reset_mdata got=%h exp=0", m_axis_tdata); end
        checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_mlast got=%b exp=0", m_axis_tlast); end
        checks++; if (cls_out_tready !== 3'b111) begin failures++; $display("FAIL reset_out_ready got=%b exp=111", cls_out_tready); end
        checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_axis_tready); end
        checks++; if (cls_in_tvalid !== 3'b000) begin failures++; $display("FAIL reset_in_valid got=%b exp=000", cls_in_tvalid); end
    endtask

    task automatic test_majority;
        int cyc;
        send_results(3'b111, 32'hABCD_EF02, 32'h1234_5602, 32'h0000_0005);
        wait_mvalid(cyc);
        checks++; if (cyc != 4) begin failures++; $display("FAIL maj_latency got=%0d exp=4", cyc); end
        checks++; if (m_axis_tdata !== 32'h0000_0202) begin failures++; $display("FAIL maj_data got=%h exp=00000202", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 4'hF) begin failures++; $display("FAIL maj_keep got=%h exp=f", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b1) begin failures++; $display("FAIL maj_last got=%b exp=1", m_axis_tlast); end
        @(posedge clk); #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL maj_release got=%b exp=0", m_axis_tvalid); end
        checks++; if (cls_out_tready !== 3'b111) begin failures++; $display("FAIL maj_reopen got=%b exp=111", cls_out_tready); end
        send_results(3'b111, 32'd3, 32'd5, 32'd5);
        wait_mvalid(cyc);
        checks++; if (m_axis_tdata !== 32'h0000_0205) begin failures++; $display("FAIL maj_late_winner got=%h exp=00000205", m_axis_tdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_tie;
        int cyc;
        cls_out_tdata  = {32'd0, 32'd0, 32'd9};
        cls_out_tvalid = 3'b001;
        cls_out_tlast  = 3'b000;
        @(posedge clk); #1;
        checks++; if (cls_out_tready !== 3'b111) begin failures++; $display("FAIL tie_nonlast_got got=%b exp=111", cls_out_tready); end
        send_results(3'b111, 32'd1, 32'd4, 32'd7);
        wait_mvalid(cyc);
        checks++; if (m_axis_tdata !== 32'h0000_0101) begin failures++; $display("FAIL tie_data got=%h exp=00000101", m_axis_tdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_fork;
        int cyc = 0;
        int low = 0;
        int base [N];
        logic done;
        for (int i = 0; i < N; i++) base[i] = rx_cnt[i];
        s_axis_tkeep = 4'h3;
        #1;
        checks++; if (cls_in_tkeep !== 12'h333) begin failures++; $display("FAIL fork_keep got=%h exp=333", cls_in_tkeep); end
        for (int k = 0; k < 4; k++) begin
            s_axis_tdata  = 32'hF000_0000 + k;
            s_axis_tlast  = (k == 3);
            s_axis_tvalid = 1'b1;
            done = 1'b0;
            while (!done && cyc < 40) begin
                cls_in_tready = (cyc < 5) ? 3'b101 : 3'b111;
                #1;
                if (k == 0 && !s_axis_tready) low++;
                if (cyc == 2) begin
                    checks++; if (cls_in_tvalid !== 3'b010) begin failures++; $display("FAIL fork_no_dup got=%b exp=010", cls_in_tvalid); end
                end
                if (k == 3) begin
                    checks++; if (cls_in_tlast !== 3'b111) begin failures++; $display("FAIL fork_last got=%b exp=111", cls_in_tlast); end
                end
                done = s_axis_tready;
                @(posedge clk); #1;
                cyc++;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cls_in_tready = 3'b111;
        checks++; if (low != 5) begin failures++; $display("FAIL fork_stall got=%0d exp=5", low); end
        for (int i = 0; i < N; i++) begin
            checks++; if (rx_cnt[i] - base[i] != 4) begin failures++; $display("FAIL fork_count ch=%0d got=%0d exp=4", i, rx_cnt[i] - base[i]); end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rx_data[i][(base[i] + k) % 8] !== 32'hF000_0000 + k) begin
                    failures++; $display("FAIL fork_order ch=%0d beat=%0d got=%h exp=%h", i, k, rx_data[i][(base[i] + k) % 8], 32'hF000_0000 + k);
                end
            end
        end
    endtask

    task automatic test_back_pressure;
        int cyc, n;
        int bad_data = 0;
        int bad_rdy  = 0;
        m_axis_tready = 1'b0;
        send_results(3'b111, 32'd6, 32'd6, 32'd1);
        wait_mvalid(cyc);
        cls_out_tdata  = {32'd8, 32'd8, 32'd3};
        cls_out_tvalid = 3'b111;
        cls_out_tlast  = 3'b111;
        for (int c = 0; c < 10; c++) begin
            if (m_axis_tdata !== 32'h0000_0206 || m_axis_tvalid !== 1'b1) bad_data++;
            if (cls_out_tready !== 3'b000) bad_rdy++;
            @(posedge clk); #1;
        end
        checks++; if (bad_data != 0) begin failures++; $display("FAIL bp_hold got=%0d_bad exp=0 data=%h", bad_data, m_axis_tdata); end
        checks++; if (bad_rdy != 0) begin failures++; $display("FAIL bp_ready got=%0d_bad exp=0", bad_rdy); end
        m_axis_tready = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (cls_out_tready !== 3'b111 && n < 10);
        @(posedge clk); #1;
        cls_out_tvalid = '0;
        cls_out_tlast  = '0;
        wait_mvalid(cyc);
        checks++; if (cyc != 4) begin failures++; $display("FAIL bp_next_latency got=%0d exp=4", cyc); end
        checks++; if (m_axis_tdata !== 32'h0000_0208) begin failures++; $display("FAIL bp_next_data got=%h exp=00000208", m_axis_tdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_vote;
        int cyc;
        int spurious = 0;
        send_results(3'b111, 32'd1, 32'd2, 32'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_mvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (cls_out_tready !== 3'b111) begin failures++; $display("FAIL rst_mid_ready got=%b exp=111", cls_out_tready); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (m_axis_tvalid !== 1'b0) spurious++;
            @(posedge clk); #1;
        end
        checks++; if (spurious != 0) begin failures++; $display("FAIL rst_mid_stale got=%0d exp=0", spurious); end
        send_results(3'b111, 32'd9, 32'd9, 32'd9);
        wait_mvalid(cyc);
        checks++; if (cyc != 4) begin failures++; $display("FAIL rst_fresh_latency got=%0d exp=4", cyc); end
        checks++; if (m_axis_tdata !== 32'h4000_0309) begin failures++; $display("FAIL rst_fresh_data got=%h exp=40000309", m_axis_tdata); end
        @(posedge clk); #1;
    endtask

`ifdef ENSEMBLE_TIMEOUT_EN
    task automatic test_timeout;
        int cyc;
        send_results(3'b011, 32'd4, 32'd4, 32'd0);
        wait_mvalid(cyc);
        checks++; if (cyc != TMO + N + 1) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", cyc, TMO + N + 1); end
        checks++; if (m_axis_tdata !== 32'h8000_0204) begin failures++; $display("FAIL tmo_data got=%h exp=80000204", m_axis_tdata); end
        @(posedge clk); #1;
        send_results(3'b100, 32'd0, 32'd0, 32'd7);
        checks++; if (cls_out_tready !== 3'b111) begin failures++; $display("FAIL tmo_discard got=%b exp=111", cls_out_tready); end
        send_results(3'b111, 32'd5, 32'd6, 32'd6);
        wait_mvalid(cyc);
        checks++; if (m_axis_tdata !== 32'h0000_0206) begin failures++; $display("FAIL tmo_next got=%h exp=00000206", m_axis_tdata); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tkeep   = 4'hF;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        cls_in_tready  = 3'b111;
        cls_out_tdata  = '0;
        cls_out_tvalid = '0;
        cls_out_tlast  = '0;
        m_axis_tready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_majority;
        test_tie;
        test_fork;
        test_back_pressure;
        test_reset_mid_vote;
`ifdef ENSEMBLE_TIMEOUT_EN
        test_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
